aes_v3_2_column_seq: RTL



---
 rtl/aes_v3_pkg.sv | 65 ++++++
 rtl/aes_v3_2.sv | 37 +++
 rtl/aes_v3_2_column_seq.sv | 112 +++++++++++
 3 files changed

// File: rtl/aes_v3_pkg.sv
// Shared definitions for the AES v3 subset-2 column sequencer: FSM encoding,
// GF(2^8) helpers used by the byte datapath, and known-answer constants.
package aes_v3_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    function automatic int steps_for(input int lanes);
        return 4 / lanes;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse, and maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] x);
        return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
    endfunction

    localparam logic [31:0] KAT_SUB_ZERO  = 32'h63636363;
    localparam logic [31:0] KAT_MIX_IN    = 32'h455313db;
    localparam logic [31:0] KAT_MIX_OUT   = 32'hbca14d8e;
    localparam logic [31:0] KAT_MIX_KEYED = 32'h435eb271;
    localparam logic [31:0] KAT_BYTE_IN   = 32'h53010053;
    localparam logic [31:0] KAT_BYTE_OUT  = 32'hed7c63ed;

endpackage

// File: rtl/aes_v3_2.sv
// Single-byte AES v3 subset-2 datapath: transforms byte bs of rs1 into its
// rotated column contribution and XORs it onto rs2.
module aes_v3_2
    import aes_v3_pkg::*;
(
    input  logic        valid,
    input  logic        dec,
    input  logic        mix,
    input  logic [1:0]  bs,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic [31:0] rd
);

    logic [7:0]  x;
    logic [7:0]  s;
    logic [31:0] word;
    logic [63:0] dbl;

    // NOTE: every variable gets a value before any branch so no latch is inferred.
    always_comb begin
        x    = valid ? rs1[{bs, 3'b000} +: 8] : 8'h00;
        s    = dec ? sbox_inv(x) : sbox_fwd(x);
        word = 32'h0;
        if (!mix) begin
            word = {24'h0, s};
        end else if (!dec) begin
            word = {gf_mul(x, 8'h03), x, x, gf_mul(x, 8'h02)};
        end else begin
            word = {gf_mul(x, 8'h0b), gf_mul(x, 8'h0d), gf_mul(x, 8'h09), gf_mul(x, 8'h0e)};
        end
        // Rotating left by one byte per bs lands the contribution in its column row.
        dbl = {word, word} << {bs, 3'b000};
        rd  = rs2 ^ (valid ? dbl[63:32] : 32'h0);
    end

endmodule

// File: rtl/aes_v3_2_column_seq.sv
// Multi-cycle column sequencer: steps LANES byte datapaths over a 32-bit column
// and XOR-accumulates their results onto an initial (round-key) word.
module aes_v3_2_column_seq
    import aes_v3_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_dec,
    input  logic        req_mix,
    input  logic [31:0] req_col,
    input  logic [31:0] req_acc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data
);

    localparam int         STEPS    = steps_for(LANES);
    localparam logic [1:0] LAST_CNT = 2'(STEPS - 1);

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
            $error("aes_v3_2_column_seq: LANES must be 1, 2 or 4");
        end
    endgenerate

    seq_state_t  state;
    seq_state_t  state_nxt;
    logic [1:0]  cnt;
    logic [31:0] acc;
    logic [31:0] col;
    logic        dec;
    logic        mix;
    logic        accept;
    logic        last_step;
    logic        lane_valid;
    logic [31:0] lane_rd [LANES];
    logic [31:0] lane_xor;

    // Ready is also masked by g_reset so nothing is accepted while reset is held.
    assign req_ready  = (state == IDLE) && !g_reset;
    assign accept     = req_valid && req_ready;
    assign lane_valid = (state == BUSY);
    assign last_step  = (cnt == LAST_CNT);
    assign rsp_valid  = (state == DONE);
    assign rsp_data   = rsp_valid ? acc : 32'h0;

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            logic [1:0] bs;
            assign bs = 2'(int'(cnt) * LANES + k);
            aes_v3_2 u_lane (
                .valid (lane_valid),
                .dec   (dec),
                .mix   (mix),
                .bs    (bs),
                .rs1   (col),
                .rs2   (32'h0),
                .rd    (lane_rd[k])
            );
        end
    endgenerate

    always_comb begin
        lane_xor = 32'h0;
        for (int k = 0; k < LANES; k++) lane_xor = lane_xor ^ lane_rd[k];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = BUSY;
            BUSY:    if (last_step) state_nxt = DONE;
            DONE:    if (rsp_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            cnt <= 2'd0;
            acc <= 32'h0;
            col <= 32'h0;
            dec <= 1'b0;
            mix <= 1'b0;
        end else if (flush) begin
            cnt <= 2'd0;
            acc <= 32'h0;
        end else if (accept) begin
            cnt <= 2'd0;
            acc <= req_acc;
            col <= req_col;
            dec <= req_dec;
            mix <= req_mix;
        end else if (state == BUSY) begin
            acc <= acc ^ lane_xor;
            cnt <= last_step ? 2'd0 : cnt + 2'd1;
        end
    end

endmodule
